serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add controller: time-shares one FULL_ADDER cell across WIDTH bit
//  positions, one bit per CLK, instead of a WIDTH-wide ripple chain.
//  Sits beside the ALU as the low-area adder option; START/BUSY/DONE handshake.
// PARAMETERS
//  WIDTH  32  operand width in bits (legal range 1..64)
// PORTS
//  CLK    in   1      clock, all state on rising edge
//  RST    in   1      asynchronous active-low reset
//  START  in   1      request; sampled only in IDLE
//  A      in   WIDTH  operand A, captured on accepted START
//  B      in   WIDTH  operand B, captured on accepted START
//  CI     in   1      carry-in, captured on accepted START
//  SUB    in   1      subtract select, captured on START (only with SERIAL_ADD_SUB_EN)
//  S      out  WIDTH  result; valid from DONE until next accepted START
//  CO     out  1      carry out of bit WIDTH-1
//  OVF    out  1      signed overflow = carry into MSB XOR CO
//  BUSY   out  1      high while in RUN
//  DONE   out  1      single-cycle pulse, result valid
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE; S=0, CO=0, OVF=0, BUSY=0, DONE=0; count=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN   on posedge with START=1: opA<=A, opB<=B, cy<=CI, count<=0,
//                  S<=0. Inputs A/B/CI are don't-care at every other time.
//    RUN  -> RUN   per cycle: FULL_ADDER(opA[0], opB[0], cy) -> s_bit, c_bit;
//                  S <= {s_bit, S[WIDTH-1:1]}; opA, opB >> 1; cy <= c_bit;
//                  count <= count+1; on count==WIDTH-1 latch cy into cmsb
//                  (carry into MSB) before update.
//    RUN  -> DONE  after the cycle with count==WIDTH-1; CO<=c_bit,
//                  OVF<=cmsb^c_bit.
//    DONE -> IDLE  unconditionally after one cycle.
//  - Latency: START sampled at edge 0; BUSY high for cycles 1..WIDTH; DONE
//    high in cycle WIDTH+1; earliest next START accepted at edge WIDTH+2.
//  - START while BUSY or DONE: ignored, no queuing.
//  - S/CO/OVF hold their value through IDLE until the next accepted START.
//  - WIDTH=1: exactly one RUN cycle; cmsb = CI.
//  - Reset mid-RUN: aborts, no DONE pulse, outputs to reset values.
//  - Counter width: clog2(WIDTH)+1 bits; no wrap reachable.
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined: SUB port present; on START with SUB=1,
//    opB<=~B and cy<=1 (CI ignored) -> S=A-B, CO=1 means no borrow.
//  SERIAL_ADD_SUB_EN undefined: no SUB port; pure A+B+CI.
// STRUCTURE
//  - Shared `defines in prj_definition.v: state encodings (IDLE/RUN/DONE),
//    default operand width.
//  - One sub-module: existing FULL_ADDER instance (single cell); everything
//    else (FSM, shift registers, counter) lives in this module.
// TESTING (WIDTH=32)
//  - A=FFFFFFFF, B=1, CI=0, START 1 cycle -> BUSY 32 cycles, DONE @33, S=0, CO=1, OVF=0.
//  - A=7FFFFFFF, B=1, CI=0 -> S=80000000, CO=0, OVF=1.
//  - A=12345678, B=0, CI=1 -> S=12345679; START pulsed during BUSY -> ignored,
//    exactly one DONE.
//  - RST low at RUN cycle 10 -> BUSY=0, S=0, no DONE; next START runs cleanly.
//  - SERIAL_ADD_SUB_EN: A=5, B=7, SUB=1 -> S=FFFFFFFE, CO=0; A=7, B=5 -> S=2, CO=1.
//  - Back-to-back: START held high -> accepted at edges 0 and 34, S/CO stable in IDLE.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add controller:
// FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single full-adder cell. The controller time-shares it across all bit positions.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller.
// One full-adder cell processes one bit per clock, LSB first, with a
// START/BUSY/DONE handshake.
// Optional build macro SERIAL_ADD_SUB_EN adds a SUB port. When SUB is set at
// START, the controller computes A-B by loading ~B and forcing the carry-in to 1.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic               cy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   s_r;
  logic               co_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  logic               s_bit_s;
  logic               c_bit_s;
  logic               last_s;
  logic [WIDTH-1:0]   s_next_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               cy_load_s;

  serial_adder_ctrl_full_adder u_fa (
    .a  (op_a_r[0]),
    .b  (op_b_r[0]),
    .ci (cy_r),
    .s  (s_bit_s),
    .co (c_bit_s)
  );

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Shift the new sum bit in at the MSB. This form also works for WIDTH=1.
  always_comb begin
    s_next_s            = s_r >> 1;
    s_next_s[WIDTH-1]   = s_bit_s;
  end

  // Select the operand B and carry-in values loaded on an accepted START.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    if (SUB) begin
      b_load_s  = ~B;
      cy_load_s = 1'b1;
    end else begin
      b_load_s  = B;
      cy_load_s = CI;
    end
`else
    b_load_s  = B;
    cy_load_s = CI;
`endif
  end

  // Control FSM together with the operand, sum and flag registers.
  // On the last bit, cy_r still holds the carry into the MSB, so the
  // overflow flag comes straight from cy_r and the cell's carry-out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      op_a_r  <= '0;
      op_b_r  <= '0;
      cy_r    <= 1'b0;
      cnt_r   <= '0;
      s_r     <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            op_a_r  <= A;
            op_b_r  <= b_load_s;
            cy_r    <= cy_load_s;
            cnt_r   <= '0;
            s_r     <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_r    <= s_next_s;
          op_a_r <= op_a_r >> 1;
          op_b_r <= op_b_r >> 1;
          cy_r   <= c_bit_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            co_r    <= c_bit_s;
            ovf_r   <= cy_r ^ c_bit_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign S    = s_r;
  assign CO   = co_r;
  assign OVF  = ovf_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl. It drives a WIDTH=32 instance
// and a WIDTH=1 instance. The subtract checks build only with SERIAL_ADD_SUB_EN.
module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        sub;
  logic [31:0] s;
  logic        co;
  logic        ovf;
  logic        busy;
  logic        done;

  logic        start1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        ci1;
  logic        sub1;
  logic [0:0]  s1;
  logic        co1;
  logic        ovf1;
  logic        busy1;
  logic        done1;

  int n_cmp;
  int n_err;

  serial_adder_ctrl #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .A     (a),
    .B     (b),
    .CI    (ci),
`ifdef SERIAL_ADD_SUB_EN
    .SUB   (sub),
`endif
    .S     (s),
    .CO    (co),
    .OVF   (ovf),
    .BUSY  (busy),
    .DONE  (done)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .CLK   (clk),
    .RST   (rst),
    .START (start1),
    .A     (a1),
    .B     (b1),
    .CI    (ci1),
`ifdef SERIAL_ADD_SUB_EN
    .SUB   (sub1),
`endif
    .S     (s1),
    .CO    (co1),
    .OVF   (ovf1),
    .BUSY  (busy1),
    .DONE  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on the 32-bit DUT, observed for 40 cycles.
  // Cycle k runs from edge k-1 to edge k. START is sampled at edge 0.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic civ, input logic subv, input logic [31:0] es,
                        input logic eco, input logic eovf, input bit glitch);
    int busy_n;
    int done_n;
    int done_at;
    logic [31:0] s_done;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    s_done  = 32'd0;
    @(negedge clk);
    a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        s_done  = s;
      end
      if (glitch && (k == 5 || k == 33)) start = 1'b1;
      else start = 1'b0;
    end
    check_value({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    check_value({tag, "_done_count"}, 64'(done_n), 64'd1);
    check_value({tag, "_done_cycle"}, 64'(done_at), 64'd33);
    check_value({tag, "_s_at_done"}, 64'(s_done), 64'(es));
    check_value({tag, "_s_idle"}, 64'(s), 64'(es));
    check_value({tag, "_co"}, 64'(co), 64'(eco));
    check_value({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  // One operation on the WIDTH=1 DUT.
  task automatic run_w1(input string tag, input logic av, input logic bv, input logic civ,
                        input logic es, input logic eco, input logic eovf);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(negedge clk);
    a1 = av; b1 = bv; ci1 = civ; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (busy1) busy_n++;
      if (done1) done_at = k;
    end
    check_value({tag, "_busy_cycles"}, 64'(busy_n), 64'd1);
    check_value({tag, "_done_cycle"}, 64'(done_at), 64'd2);
    check_value({tag, "_s"}, 64'(s1), 64'(es));
    check_value({tag, "_co"}, 64'(co1), 64'(eco));
    check_value({tag, "_ovf"}, 64'(ovf1), 64'(eovf));
  endtask

  initial begin
    int done_n;
    int rise_n;
    int rise1;
    int rise2;
    int done2_at;
    logic prev_busy;
    n_cmp = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0; ci = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_s", 64'(s), 64'd0);
    check_value("rst_co", 64'(co), 64'd0);
    check_value("rst_ovf", 64'(ovf), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_done", 64'(done), 64'd0);
    rst = 1'b1;

    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("cin",  32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5679, 1'b0, 1'b0, 1'b1);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a run, then check for a clean rerun.
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("midrst_busy", 64'(busy), 64'd0);
    check_value("midrst_s", 64'(s), 64'd0);
    check_value("midrst_co", 64'(co), 64'd0);
    check_value("midrst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    check_value("midrst_no_done", 64'(done_n), 64'd0);
    run_op("after_rst", 32'h0000_0011, 32'h0000_0022, 1'b1, 1'b0, 32'h0000_0034, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
`endif

    // Hold START high across two operations.
    // The second START should be accepted at edge 34.
    @(negedge clk);
    a = 32'd1; b = 32'd2; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    rise_n = 0; rise1 = 0; rise2 = 0; done2_at = 0; prev_busy = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        rise_n++;
        if (rise_n == 1) rise1 = k;
        else if (rise_n == 2) rise2 = k;
      end
      prev_busy = busy;
      if (done && k > 40) done2_at = k;
      if (k == 1) begin
        a = 32'd10; b = 32'd20;
      end
      if (k == 34) begin
        check_value("b2b_s_idle", 64'(s), 64'd3);
        check_value("b2b_co_idle", 64'(co), 64'd0);
      end
      if (k == 35) start = 1'b0;
    end
    check_value("b2b_rise1", 64'(rise1), 64'd1);
    check_value("b2b_rise2", 64'(rise2), 64'd35);
    check_value("b2b_rises", 64'(rise_n), 64'd2);
    check_value("b2b_done2", 64'(done2_at), 64'd67);
    check_value("b2b_s2", 64'(s), 64'd30);

    run_w1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_w1("w1_cin", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_w1("w1_01", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
